// File: rtl/serial_sub.sv
// Bit-serial unsigned subtractor: one full-subtractor cell plus a registered borrow,
// LSB first, with parallel operand load and result return over valid/ready handshakes.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for operands; in_ready high once out of reset
// RUN   | one difference bit per edge, WIDTH edges total
// DONE  | diff/borrow presented with out_valid until out_ready
module serial_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] sr;
    logic             br;
    logic [CW-1:0]    cnt;

    logic             d_bit;
    logic             br_next;
    logic [WIDTH-1:0] sr_next;

    always_comb begin
        d_bit   = sa[0] ^ sb[0] ^ br;
        br_next = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
        sr_next = {d_bit, sr[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            sa        <= '0;
            sb        <= '0;
            sr        <= '0;
            br        <= 1'b0;
            cnt       <= '0;
            diff      <= '0;
            borrow    <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    // in_ready is still low on the first edge after reset release
                    if (in_valid && in_ready) begin
                        sa       <= a;
                        sb       <= b;
                        sr       <= '0;
                        br       <= 1'b0;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    sa <= sa >> 1;
                    sb <= sb >> 1;
                    sr <= sr_next;
                    br <= br_next;
                    if (cnt == CNT_LAST) begin
                        // cnt holds here so it never wraps inside an operation
                        diff      <= sr_next;
                        borrow    <= br_next;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub.sv
// Scoreboard bench for serial_sub: directed vectors push expected results,
// an independent monitor pops and compares at each output handshake.
module tb_serial_sub;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] diff;
    logic             borrow;

    always #5 clk = ~clk;

    serial_sub #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow)
    );

    typedef struct packed {
        logic [WIDTH-1:0] d;
        logic             br;
        int               acc;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   accepts = 0;
    int   results = 0;
    int   rdy_mode = 0;     // 0: always ready, 1: random, 2: manual_rdy
    logic manual_rdy = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #2;
        if (rdy_mode == 0)      out_ready = 1'b1;
        else if (rdy_mode == 1) out_ready = 1'($urandom_range(0, 1));
        else                    out_ready = manual_rdy;
    end

    // Monitor: latency on out_valid rise, value compare at each output handshake.
    initial begin
        logic prev_ov;
        exp_t e;
        prev_ov = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (out_valid && !prev_ov) begin
                    if (sbq.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_out_valid: got out_valid=1 required no pending result (cycle %0d)", cyc);
                    end else begin
                        check("latency", 32'(cyc - sbq[0].acc), WIDTH);
                    end
                end
                if (out_valid && out_ready && sbq.size() != 0) begin
                    e = sbq.pop_front();
                    check("diff", 32'(diff), 32'(e.d));
                    check("borrow", 32'(borrow), 32'(e.br));
                    results++;
                end
            end
            prev_ov = out_valid;
        end
    end

    task automatic send(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                        input logic [WIDTH-1:0] ed, input logic eb, input bit hold,
                        output int acc_cyc);
        int n;
        n = 0;
        acc_cyc = -1;
        @(posedge clk);
        #1;
        a = av;
        b = bv;
        in_valid = 1'b1;
        while (1) begin
            @(negedge clk);
            if (in_ready && rst_n) break;
            n++;
            if (n > 200) begin
                check("accept_timeout", 32'(in_ready), 1);
                in_valid = 1'b0;
                return;
            end
        end
        acc_cyc = cyc + 1;
        sbq.push_back('{d: ed, br: eb, acc: acc_cyc});
        accepts++;
        if (!hold) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(sbq.size()), 0);
        @(posedge clk);
        #1;
    endtask

    typedef struct packed {
        logic [WIDTH-1:0] av;
        logic [WIDTH-1:0] bv;
        logic [WIDTH-1:0] ed;
        logic             eb;
    } vec_t;

    initial begin
        vec_t vecs[4];
        int   acc0, acc1, n;
        logic seen;
        logic [WIDTH-1:0] ra, rb;

        vecs[0] = '{av: 8'h03, bv: 8'h05, ed: 8'hFE, eb: 1'b1};
        vecs[1] = '{av: 8'h00, bv: 8'h01, ed: 8'hFF, eb: 1'b1};
        vecs[2] = '{av: 8'hFF, bv: 8'hFF, ed: 8'h00, eb: 1'b0};
        vecs[3] = '{av: 8'h80, bv: 8'h01, ed: 8'h7F, eb: 1'b0};

        // reset for two edges
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_diff", 32'(diff), 0);
        check("rst_borrow", 32'(borrow), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("release_in_ready_low", 32'(in_ready), 0);
        @(negedge clk);
        check("release_in_ready", 32'(in_ready), 1);

        send(8'd5, 8'd3, 8'h02, 1'b0, 1'b0, acc0);
        wait_drain();

        foreach (vecs[i]) send(vecs[i].av, vecs[i].bv, vecs[i].ed, vecs[i].eb, 1'b0, acc0);
        wait_drain();

        // back-pressure
        rdy_mode = 2;
        manual_rdy = 1'b0;
        send(8'h10, 8'h20, 8'hF0, 1'b1, 1'b0, acc0);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            check("bp_out_valid", 32'(out_valid), 1);
            check("bp_diff", 32'(diff), 32'h0F0);
            check("bp_borrow", 32'(borrow), 1);
            check("bp_in_ready", 32'(in_ready), 0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        manual_rdy = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_release_out_valid", 32'(out_valid), 0);
        check("bp_release_in_ready", 32'(in_ready), 1);
        rdy_mode = 0;
        wait_drain();

        // in_valid held through RUN/DONE with new operands
        send(8'd5, 8'd3, 8'h02, 1'b0, 1'b1, acc0);
        send(8'd9, 8'd4, 8'h05, 1'b0, 1'b0, acc1);
        check("hold_issue_interval", 32'(acc1 - acc0), WIDTH + 2);
        wait_drain();

        // reset pulse in the middle of RUN
        send(8'h20, 8'h10, 8'h10, 1'b0, 1'b0, acc0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        accepts -= sbq.size();
        sbq.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_diff", 32'(diff), 0);
        check("abort_borrow", 32'(borrow), 0);
        @(negedge clk);
        check("abort_in_ready", 32'(in_ready), 1);
        seen = 1'b0;
        for (int i = 0; i < WIDTH + 4; i++) begin
            if (out_valid) seen = 1'b1;
            @(negedge clk);
        end
        check("abort_no_out_valid", 32'(seen), 0);
        send(8'd7, 8'd2, 8'h05, 1'b0, 1'b0, acc0);
        wait_drain();

        // random sweep with random back-pressure
        rdy_mode = 1;
        for (int i = 0; i < 1000; i++) begin
            ra = WIDTH'($urandom_range(0, 255));
            rb = WIDTH'($urandom_range(0, 255));
            send(ra, rb, ra - rb, (ra < rb), 1'b0, acc0);
        end
        wait_drain();
        rdy_mode = 0;
        check("result_count", 32'(results), 32'(accepts));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
